// File: rtl/alu_uart_sequencer_if.sv
// Byte/ALU/transmit signal bundle for alu_uart_sequencer.
// slave is the sequencer side, master the UART/ALU side.
interface alu_uart_sequencer_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
);
  logic [NB_DATA-1:0] i_rx_data;
  logic               i_rx_done;
  logic               i_tx_done;
  logic [NB_DATA-1:0] i_result;
  logic [NB_DATA-1:0] o_data_a;
  logic [NB_DATA-1:0] o_data_b;
  logic [NB_OP-1:0]   o_op;
  logic               o_valid;
  logic               o_tx_start;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_busy;
  logic               o_timeout;
  logic               o_overrun;

  modport slave (
    input  i_rx_data, i_rx_done, i_tx_done, i_result,
    output o_data_a, o_data_b, o_op, o_valid,
    output o_tx_start, o_tx_data, o_busy,
    output o_timeout, o_overrun
  );

  modport master (
    output i_rx_data, i_rx_done, i_tx_done, i_result,
    input  o_data_a, o_data_b, o_op, o_valid,
    input  o_tx_start, o_tx_data, o_busy,
    input  o_timeout, o_overrun
  );
endinterface

// File: rtl/alu_uart_sequencer.sv
// Collects A, B, OP bytes from a UART receiver, fires the ALU,
// and sends the result byte back through the UART transmitter.
module alu_uart_sequencer #(
  parameter int NB_DATA     = 8,
  parameter int NB_OP       = 6,
  parameter int TIMEOUT_CYC = 250_000
) (
  input logic                 clk,
  input logic                 i_rst,
  alu_uart_sequencer_if.slave bus
);

  localparam int NB_CNT =
    (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [NB_CNT-1:0] CNT_TERM =
    NB_CNT'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    GET_B,
    GET_OP,
    EXEC,
    SEND,
    WAIT_TX
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NB_CNT-1:0]   r_cnt;
  logic [NB_DATA-1:0]  r_data_a;
  logic [NB_DATA-1:0]  r_data_b;
  logic [NB_OP-1:0]    r_op;
  logic                r_valid;
  logic                r_tx_start;
  logic [NB_DATA-1:0]  r_tx_data;
  logic                r_busy;
  logic                r_timeout;
  logic                r_overrun;

  logic w_ld_a;
  logic w_ld_b;
  logic w_ld_op;
  logic w_abort;
  logic w_cnt_inc;
  logic w_ovr;
  logic w_exec;
  logic w_term;

  assign w_term = (r_cnt == CNT_TERM);
  assign w_exec = (r_state == EXEC);

  // State register; reset drops any frame in flight.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_ld_a      = 1'b0;
    w_ld_b      = 1'b0;
    w_ld_op     = 1'b0;
    w_abort     = 1'b0;
    w_cnt_inc   = 1'b0;
    w_ovr       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.i_rx_done) begin
          w_ld_a      = 1'b1;
          w_state_nxt = GET_B;
        end
      end
      GET_B: begin
        if (bus.i_rx_done) begin
          w_ld_b      = 1'b1;
          w_state_nxt = GET_OP;
        end else if (w_term) begin
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_inc   = 1'b1;
        end
      end
      GET_OP: begin
        if (bus.i_rx_done) begin
          w_ld_op     = 1'b1;
          w_state_nxt = EXEC;
        end else if (w_term) begin
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_inc   = 1'b1;
        end
      end
      EXEC: begin
        w_ovr       = bus.i_rx_done;
        w_state_nxt = SEND;
      end
      SEND: begin
        w_ovr       = bus.i_rx_done;
        w_state_nxt = WAIT_TX;
      end
      WAIT_TX: begin
        w_ovr = bus.i_rx_done;
        if (bus.i_tx_done) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Inter-byte counter: runs only while waiting for B or OP.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_cnt_inc) begin
      r_cnt <= r_cnt + NB_CNT'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  // Operand/opcode registers, cleared when a frame times out.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_data_a <= '0;
      r_data_b <= '0;
      r_op     <= '0;
    end else if (w_abort) begin
      r_data_a <= '0;
      r_data_b <= '0;
      r_op     <= '0;
    end else begin
      if (w_ld_a) r_data_a <= bus.i_rx_data;
      if (w_ld_b) r_data_b <= bus.i_rx_data;
      if (w_ld_op) r_op <= bus.i_rx_data[NB_OP-1:0];
    end
  end

  // Result capture, pulses and registered busy decode.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid    <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_valid    <= w_ld_op;
      r_tx_start <= w_exec;
      r_busy     <= (w_state_nxt != IDLE);
      r_timeout  <= w_abort;
      r_overrun  <= w_ovr;
      if (w_exec) r_tx_data <= bus.i_result;
    end
  end

  assign bus.o_data_a   = r_data_a;
  assign bus.o_data_b   = r_data_b;
  assign bus.o_op       = r_op;
  assign bus.o_valid    = r_valid;
  assign bus.o_tx_start = r_tx_start;
  assign bus.o_tx_data  = r_tx_data;
  assign bus.o_busy     = r_busy;
  assign bus.o_timeout  = r_timeout;
  assign bus.o_overrun  = r_overrun;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Directed bench for alu_uart_sequencer: frames, timeout,
// terminal-count acceptance, overrun and mid-frame reset.
module tb_alu_uart_sequencer;

  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;
  localparam int TMO     = 16;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  int   n_tmo;
  int   n_ovr;

  alu_uart_sequencer_if #(
    .NB_DATA(NB_DATA),
    .NB_OP  (NB_OP)
  ) bus ();

  alu_uart_sequencer #(
    .NB_DATA    (NB_DATA),
    .NB_OP      (NB_OP),
    .TIMEOUT_CYC(TMO)
  ) u_dut (
    .clk  (clk),
    .i_rst(rst),
    .bus  (bus)
  );

  // ALU model: adder
  assign bus.i_result = bus.o_data_a + bus.o_data_b;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (bus.o_timeout === 1'b1) n_tmo++;
    if (bus.o_overrun === 1'b1) n_ovr++;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h exp 0x%0h",
               tag, got, exp);
    end
  endtask

  // rx_done high for the cycle after the next negedge
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    @(negedge clk);
    bus.i_rx_done = 1'b0;
  endtask

  task automatic tx_ack();
    @(negedge clk);
    bus.i_tx_done = 1'b1;
    @(negedge clk);
    bus.i_tx_done = 1'b0;
  endtask

  // called in cycle N+1 after the OP byte
  task automatic close_frame(
    input string      tag,
    input logic [7:0] exp_tx
  );
    chk({tag, "_valid"}, 32'(bus.o_valid), 1);
    chk({tag, "_start0"}, 32'(bus.o_tx_start), 0);
    @(negedge clk);
    chk({tag, "_valid_off"}, 32'(bus.o_valid), 0);
    chk({tag, "_start"}, 32'(bus.o_tx_start), 1);
    chk({tag, "_txdata"}, 32'(bus.o_tx_data), 32'(exp_tx));
    @(negedge clk);
    chk({tag, "_start_off"}, 32'(bus.o_tx_start), 0);
    chk({tag, "_busy_wait"}, 32'(bus.o_busy), 1);
    tx_ack();
    chk({tag, "_idle"}, 32'(bus.o_busy), 0);
  endtask

  initial begin
    int first;
    int base;
    n_vec = 0;
    n_err = 0;
    n_tmo = 0;
    n_ovr = 0;
    rst = 1'b1;
    bus.i_rx_data = '0;
    bus.i_rx_done = 1'b0;
    bus.i_tx_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.o_busy), 0);
    chk("rst_a", 32'(bus.o_data_a), 0);
    chk("rst_txd", 32'(bus.o_tx_data), 0);
    chk("rst_valid", 32'(bus.o_valid), 0);
    rst = 1'b0;
    @(negedge clk);

    // basic frame 05 03 20 -> 08
    send_byte(8'h05);
    chk("f1_busy_b", 32'(bus.o_busy), 1);
    send_byte(8'h03);
    send_byte(8'h20);
    chk("f1_a", 32'(bus.o_data_a), 32'h05);
    chk("f1_b", 32'(bus.o_data_b), 32'h03);
    chk("f1_op", 32'(bus.o_op), 32'h20);
    close_frame("f1", 8'h08);

    // upper opcode bits dropped; tx_done in GET_B ignored
    send_byte(8'h01);
    tx_ack();
    chk("f2_txdone_ign", 32'(bus.o_busy), 1);
    send_byte(8'h02);
    send_byte(8'hE0);
    chk("f2_op", 32'(bus.o_op), 32'h20);
    close_frame("f2", 8'h03);

    // timeout in GET_OP
    send_byte(8'h11);
    send_byte(8'h22);
    base  = n_tmo;
    first = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.o_timeout && first == 0) first = i;
    end
    chk("tmo_at", 32'(first), 32'(TMO));
    chk("tmo_cnt", 32'(n_tmo - base), 1);
    chk("tmo_busy", 32'(bus.o_busy), 0);
    chk("tmo_a", 32'(bus.o_data_a), 0);
    chk("tmo_b", 32'(bus.o_data_b), 0);
    chk("tmo_op", 32'(bus.o_op), 0);
    send_byte(8'h07);
    chk("tmo_next_a", 32'(bus.o_data_a), 32'h07);
    send_byte(8'h01);
    send_byte(8'h20);
    close_frame("f3", 8'h08);

    // OP byte exactly at terminal count
    base = n_tmo;
    send_byte(8'h0A);
    send_byte(8'h04);
    repeat (TMO - 2) @(negedge clk);
    send_byte(8'h20);
    chk("term_op", 32'(bus.o_op), 32'h20);
    chk("term_no_tmo", 32'(n_tmo - base), 0);
    close_frame("term", 8'h0E);

    // overrun in WAIT_TX
    send_byte(8'h05);
    send_byte(8'h03);
    send_byte(8'h20);
    @(negedge clk);
    @(negedge clk);
    base = n_ovr;
    send_byte(8'h55);
    chk("ovr_pulse", 32'(bus.o_overrun), 1);
    chk("ovr_busy", 32'(bus.o_busy), 1);
    chk("ovr_txd", 32'(bus.o_tx_data), 32'h08);
    chk("ovr_a", 32'(bus.o_data_a), 32'h05);
    @(negedge clk);
    chk("ovr_once", 32'(n_ovr - base), 1);
    chk("ovr_start", 32'(bus.o_tx_start), 0);
    tx_ack();
    chk("ovr_idle", 32'(bus.o_busy), 0);

    // async reset in GET_OP, tx_done pending at release
    send_byte(8'h33);
    send_byte(8'h44);
    #2;
    rst = 1'b1;
    bus.i_tx_done = 1'b1;
    #1;
    chk("arst_busy", 32'(bus.o_busy), 0);
    chk("arst_a", 32'(bus.o_data_a), 0);
    chk("arst_b", 32'(bus.o_data_b), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.i_tx_done = 1'b0;
    chk("arst_txd_ign", 32'(bus.o_busy), 0);
    send_byte(8'h01);
    chk("arst_a1", 32'(bus.o_data_a), 32'h01);
    send_byte(8'h02);
    send_byte(8'h20);
    chk("arst_b2", 32'(bus.o_data_b), 32'h02);
    close_frame("arst", 8'h03);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
